// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit.
//   master: issues requests (in_valid, aluop, funct, op_a, op_b) and consumes results (out_ready)
//   slave : the ALU; returns in_ready, out_valid, result_lo/hi and status flags
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             illegal;
  logic             div_zero;

  modport master (
    output in_valid, aluop, funct, op_a, op_b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, zero, illegal, div_zero
  );

  modport slave (
    input  in_valid, aluop, funct, op_a, op_b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, zero, illegal, div_zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: decodes ALUOp/funct, executes single-cycle ops in one registered
// cycle and unsigned mul/div iteratively over WIDTH cycles.
// Ports: clk, rst_n (async active-low, synchronously released internally),
//        bus (alu_seq_unit_if.slave: request handshake, operands, result handshake, flags).
// Optional macro ALU_SEQ_DIV_EN: includes the restoring divider; when undefined
// div decodes as illegal and div_zero is tied low.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_unit_if.slave  bus
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
    OP_XOR, OP_SLT, OP_SLL, OP_SRL, OP_NEQ, OP_ILL
  } op_t;

  state_t            state_q, state_nx;
  op_t               op_dec;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic              accept, start_exec, div_by_zero, last_iter;
  logic [WIDTH-1:0]  sc_lo, sc_hi;
  logic [WIDTH-1:0]  acc_hi_q, acc_lo_q, acc_hi_nx, acc_lo_nx;
  logic [WIDTH-1:0]  opnd_q, addend;
  logic [WIDTH:0]    mul_sum;
  logic [CNTW-1:0]   cnt_q;
  logic              in_ready_q, out_valid_q, zero_q, illegal_q;
  logic [WIDTH-1:0]  result_lo_q, result_hi_q;
`ifdef ALU_SEQ_DIV_EN
  logic              is_div_q, div_zero_q;
  logic [WIDTH:0]    div_trial;
`endif

  // Reset: asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Operation decode from ALUOp/funct
  always_comb begin
    op_dec = OP_ILL;
    case (bus.aluop)
      3'b000: op_dec = OP_ADD;
      3'b001: op_dec = OP_SUB;
      3'b010: begin
        case (bus.funct)
          6'b100000: op_dec = OP_ADD;
          6'b100010: op_dec = OP_SUB;
          6'b011000: op_dec = OP_MUL;
`ifdef ALU_SEQ_DIV_EN
          6'b011010: op_dec = OP_DIV;
`endif
          6'b100100: op_dec = OP_AND;
          6'b100101: op_dec = OP_OR;
          6'b100110: op_dec = OP_XOR;
          6'b101010: op_dec = OP_SLT;
          6'b000000: op_dec = OP_SLL;
          6'b000010: op_dec = OP_SRL;
          default:   op_dec = OP_ILL;
        endcase
      end
      3'b011: op_dec = OP_AND;
      3'b100: op_dec = OP_OR;
      3'b101: op_dec = OP_SLT;
      3'b110: op_dec = OP_NEQ;
      default: op_dec = OP_ILL;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;
`ifdef ALU_SEQ_DIV_EN
  assign div_by_zero = (op_dec == OP_DIV) && (bus.op_b == '0);
`else
  assign div_by_zero = 1'b0;
`endif
  assign start_exec = (op_dec == OP_MUL) || ((op_dec == OP_DIV) && !div_by_zero);
  assign last_iter  = (state_q == ST_EXEC) && (cnt_q == CNTW'(WIDTH - 1));

  // Single-cycle results straight from the request operands
  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    case (op_dec)
      OP_ADD: sc_lo = bus.op_a + bus.op_b;
      OP_SUB: sc_lo = bus.op_a - bus.op_b;
      OP_AND: sc_lo = bus.op_a & bus.op_b;
      OP_OR:  sc_lo = bus.op_a | bus.op_b;
      OP_XOR: sc_lo = bus.op_a ^ bus.op_b;
      OP_SLT: sc_lo[0] = $signed(bus.op_a) < $signed(bus.op_b);
      OP_NEQ: sc_lo[0] = bus.op_a != bus.op_b;
      OP_SLL: sc_lo = bus.op_a << bus.op_b[SHW-1:0];
      OP_SRL: sc_lo = bus.op_a >> bus.op_b[SHW-1:0];
      OP_DIV: begin
        // only reached as single-cycle when the divisor is zero
        sc_lo = '1;
        sc_hi = bus.op_a;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase
  end

  // One iteration: shift-add multiply or restoring-divide step on {acc_hi, acc_lo}
  always_comb begin
    addend  = acc_lo_q[0] ? opnd_q : '0;
    mul_sum = {1'b0, acc_hi_q} + {1'b0, addend};
    {acc_hi_nx, acc_lo_nx} = {mul_sum, acc_lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        acc_hi_nx = div_trial[WIDTH-1:0];
        acc_lo_nx = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_nx = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        acc_lo_nx = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= ST_IDLE;
    else            state_q <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_nx = start_exec ? ST_EXEC : ST_DONE;
      ST_EXEC: if (last_iter) state_nx = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div_q    <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      in_ready_q  <= (state_nx == ST_IDLE);
      out_valid_q <= (state_nx == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (start_exec) begin
              // mul: acc_lo holds multiplier, opnd multiplicand; div: acc_lo dividend, opnd divisor
              opnd_q   <= (op_dec == OP_MUL) ? bus.op_a : bus.op_b;
              acc_hi_q <= '0;
              acc_lo_q <= (op_dec == OP_MUL) ? bus.op_b : bus.op_a;
`ifdef ALU_SEQ_DIV_EN
              is_div_q <= (op_dec == OP_DIV);
`endif
            end else begin
              result_lo_q <= sc_lo;
              result_hi_q <= sc_hi;
              zero_q      <= (sc_lo == '0);
              illegal_q   <= (op_dec == OP_ILL);
`ifdef ALU_SEQ_DIV_EN
              div_zero_q  <= div_by_zero;
`endif
            end
          end
        end
        ST_EXEC: begin
          acc_hi_q <= acc_hi_nx;
          acc_lo_q <= acc_lo_nx;
          cnt_q    <= cnt_q + CNTW'(1);
          if (last_iter) begin
            result_lo_q <= acc_lo_nx;
            result_hi_q <= acc_hi_nx;
            zero_q      <= (acc_lo_nx == '0);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            result_lo_q <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_zero_q  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result_lo = result_lo_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
`ifdef ALU_SEQ_DIV_EN
  assign bus.div_zero  = div_zero_q;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH = 32).
module tb_alu_seq_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  int         r_lat, r_busy;
  logic [W-1:0] r_lo, r_hi;
  logic       r_zero, r_ill, r_dz;
  int         vcount;

  alu_seq_unit_if #(.WIDTH(W)) bus();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request (out_ready held high), scramble inputs after acceptance,
  // and record latency, busy cycles and the result seen while out_valid = 1.
  task automatic run_op(input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid  = 1'b1;
    bus.aluop     = op;
    bus.funct     = fn;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.funct    = ~fn;
    r_lat = -1; r_busy = 0;
    r_lo = '0; r_hi = '0; r_zero = 1'b0; r_ill = 1'b0; r_dz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!bus.in_ready) r_busy++;
      if (bus.out_valid && r_lat < 0) begin
        r_lat  = k;
        r_lo   = bus.result_lo;
        r_hi   = bus.result_hi;
        r_zero = bus.zero;
        r_ill  = bus.illegal;
        r_dz   = bus.div_zero;
      end
      if (bus.in_ready) break;
      @(negedge clk);
    end
  endtask

  task automatic expect_res(input string tag, input int lat, input logic [W-1:0] lo,
                            input logic [W-1:0] hi, input logic z, input logic ill, input logic dz);
    check({tag, ".lat"},  64'(r_lat),  64'(lat));
    check({tag, ".busy"}, 64'(r_busy), 64'(lat));
    check({tag, ".lo"},   64'(r_lo),   64'(lo));
    check({tag, ".hi"},   64'(r_hi),   64'(hi));
    check({tag, ".zero"}, 64'(r_zero), 64'(z));
    check({tag, ".ill"},  64'(r_ill),  64'(ill));
    check({tag, ".dz"},   64'(r_dz),   64'(dz));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.aluop = '0; bus.funct = '0;
    bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready",  64'(bus.in_ready),  64'(1));
    check("rst.out_valid", 64'(bus.out_valid), 64'(0));
    check("rst.lo",        64'(bus.result_lo), 64'(0));
    check("rst.hi",        64'(bus.result_hi), 64'(0));
    check("rst.zero",      64'(bus.zero),      64'(0));
    check("rst.ill",       64'(bus.illegal),   64'(0));
    check("rst.dz",        64'(bus.div_zero),  64'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // add wraps to zero
    run_op(3'b010, 6'b100000, 32'hFFFF_FFFF, 32'h1);
    expect_res("add", 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("add.ready_after", 64'(bus.in_ready),  64'(1));
    check("add.valid_after", 64'(bus.out_valid), 64'(0));

    // unsigned multiply
    run_op(3'b010, 6'b011000, 32'hFFFF_FFFF, 32'h2);
    expect_res("mul", 33, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_DIV_EN
    run_op(3'b010, 6'b011010, 32'd100, 32'd7);
    expect_res("div", 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op(3'b010, 6'b011010, 32'd100, 32'd0);
    expect_res("div0", 1, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 1'b1);
`else
    run_op(3'b010, 6'b011010, 32'd100, 32'd7);
    expect_res("div_off", 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op(3'b010, 6'b011010, 32'd100, 32'd0);
    expect_res("div0_off", 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
`endif

    run_op(3'b101, 6'b000000, 32'hFFFF_FFFE, 32'd3);
    expect_res("slt", 1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(3'b110, 6'b000000, 32'd5, 32'd5);
    expect_res("neq", 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op(3'b111, 6'b100000, 32'd9, 32'd4);
    expect_res("ill_aluop", 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op(3'b010, 6'b111111, 32'd9, 32'd4);
    expect_res("ill_funct", 1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op(3'b001, 6'b000000, 32'd3, 32'd5);
    expect_res("sub", 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(3'b010, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00);
    expect_res("xor", 1, 32'h0FF0_0FF0, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(3'b010, 6'b000010, 32'h8000_0000, 32'h0000_003F);
    expect_res("srl", 1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);

    // sll held with out_ready low; inputs churn and in_valid pulses meanwhile
    bus.in_valid = 1'b1; bus.aluop = 3'b010; bus.funct = 6'b000000;
    bus.op_a = 32'd1; bus.op_b = 32'd31; bus.out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("hold.valid", 64'(bus.out_valid), 64'(1));
      check("hold.lo",    64'(bus.result_lo), 64'(32'h8000_0000));
      check("hold.ready", 64'(bus.in_ready),  64'(0));
      bus.in_valid = 1'(i % 2);
      bus.funct    = 6'b100000;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold.valid_drop", 64'(bus.out_valid), 64'(0));
    check("hold.ready_back", 64'(bus.in_ready),  64'(1));
    repeat (2) @(negedge clk);
    check("hold.lo_clear",   64'(bus.result_lo), 64'(0));
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) vcount++;
      @(negedge clk);
    end
    check("hold.no_queued", 64'(vcount), 64'(0));

    // reset in the middle of a multiply
    bus.in_valid = 1'b1; bus.aluop = 3'b010; bus.funct = 6'b011000;
    bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'h2; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("abort.valid", 64'(bus.out_valid), 64'(0));
    check("abort.ready", 64'(bus.in_ready),  64'(1));
    check("abort.lo",    64'(bus.result_lo), 64'(0));
    check("abort.hi",    64'(bus.result_hi), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) vcount++;
      @(negedge clk);
    end
    check("abort.no_result", 64'(vcount),       64'(0));
    check("abort.ready_end", 64'(bus.in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
